// File: rtl/conv_encoder.sv
// Rate-1/2 feed-forward convolutional encoder with valid/ready in and registered valid/ready out.
// Define ENC_TAIL_EN to append K-1 zero tail symbols per frame so the trellis ends in state 0.
module conv_encoder #(
  parameter int             K  = 3,
  parameter logic [K-1:0]   G0 = 3'b111,
  parameter logic [K-1:0]   G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic       busy
);

`ifdef ENC_TAIL_EN
  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;
  localparam state_t FRAME_END = TAIL;
`else
  typedef enum logic [1:0] {IDLE, DATA} state_t;
  localparam state_t FRAME_END = IDLE;
`endif

  state_t         state, state_nxt;
  logic [K-2:0]   sr;
  logic [K-1:0]   w;
  logic [1:0]     sym;
  logic           in_tail, last_sym, out_free, in_fire, tail_fire, load, cur_bit;

`ifdef ENC_TAIL_EN
  localparam int TCW = (K > 2) ? $clog2(K-1) : 1;
  logic [TCW-1:0] tail_cnt;
  logic           tail_done;

  assign in_tail   = (state == TAIL);
  assign tail_done = tail_fire && (tail_cnt == TCW'(K-2));
  assign last_sym  = tail_done;
`else
  assign in_tail   = 1'b0;
  assign last_sym  = in_last;
`endif

  // A new symbol may be loaded whenever the output slot is empty or being drained.
  assign out_free  = !out_valid || out_ready;
  assign in_ready  = !rst && !in_tail && out_free;
  assign in_fire   = in_valid && in_ready;
  assign tail_fire = in_tail && out_free;
  assign load      = in_fire || tail_fire;
  assign cur_bit   = !in_tail && in_bit;
  // w[0] is the current bit, w[i] the bit from i steps earlier
  assign w         = {sr, cur_bit};
  assign sym       = {^(G0 & w), ^(G1 & w)};
  assign busy      = !rst && (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_fire) state_nxt = in_last ? FRAME_END : DATA;
      DATA: if (in_fire && in_last) state_nxt = FRAME_END;
`ifdef ENC_TAIL_EN
      TAIL: if (tail_done) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      out_valid <= 1'b0;
      out_sym   <= 2'b00;
      out_last  <= 1'b0;
`ifdef ENC_TAIL_EN
      tail_cnt  <= '0;
`endif
    end else begin
      if (load) begin
`ifdef ENC_TAIL_EN
        // zero tail bits flush sr to all-zero by the last tail step
        sr <= w[K-2:0];
`else
        sr <= in_last ? '0 : w[K-2:0];
`endif
        out_valid <= 1'b1;
        out_sym   <= sym;
        out_last  <= last_sym;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
`ifdef ENC_TAIL_EN
      if (in_fire)        tail_cnt <= '0;
      else if (tail_fire) tail_cnt <= tail_done ? '0 : tail_cnt + TCW'(1);
`endif
    end
  end

endmodule

// File: doc/conv_encoder.md
Name: conv_encoder

Overview:
- Rate-1/2 feed-forward convolutional encoder; the transmit-side counterpart of the Viterbi decoder datapath.
- Takes a framed serial bit stream over a valid/ready handshake.
- Emits one 2-bit coded symbol per input bit on a registered valid/ready output.
- Appends K-1 zero tail bits per frame so the decoder trellis terminates in state 0.

Parameters:
- K, 3, constraint length; the shift register holds K-1 past bits (K-1 = 2 gives the 4-state trellis).
- G0, 3'b111, generator for symbol bit 1; width K; bit i multiplies the input from i bits earlier.
- G1, 3'b101, generator for symbol bit 0; same indexing as G0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input bit valid
- in_ready  out  1  encoder can accept an input bit this cycle
- in_bit  in  1  data bit
- in_last  in  1  final data bit of the frame; qualified by in_valid
- out_valid  out  1  out_sym holds a valid symbol
- out_ready  in  1  downstream accepts the symbol
- out_sym  out  2  coded symbol: [1] = G0 parity, [0] = G1 parity
- out_last  out  1  final symbol of the frame
- busy  out  1  high in the DATA and TAIL states

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE, sr=0, tail_cnt=0, out_valid=0, out_sym=0, out_last=0. in_ready and busy drop to 0 combinationally while rst is high.
- Window: w[0] = current bit (in_bit, or 0 during tail); w[i] = sr[i-1] for i = 1..K-1.
- Parity: sym[1] = XOR-reduce(G0 & w); sym[0] = XOR-reduce(G1 & w).
- Accept: in_fire = in_valid & in_ready. Tail step: tail_fire = (state==TAIL) & (!out_valid | out_ready).
- Shift on in_fire or tail_fire: sr <= {sr[K-3:0], w[0]}.
- Output register: loaded on in_fire or tail_fire with out_valid=1, out_sym=sym, out_last as defined below. Latency is 1 cycle from fire to out_valid.
- Output hold: when out_valid & !out_ready, out_sym and out_last are held stable.
- Output clear: when out_valid & out_ready with no new load, out_valid <= 0.
- in_ready = !rst & (state != TAIL) & (!out_valid | out_ready). Full throughput: 1 symbol/clk under no backpressure.
- FSM:
  - IDLE: sr == 0. in_fire with in_last=0 -> DATA. in_fire with in_last=1 -> TAIL (tail_cnt=0).
  - DATA: in_fire with in_last=1 -> TAIL (tail_cnt=0); otherwise stay.
  - TAIL: emits K-1 symbols, one per tail_fire, with w[0]=0. tail_cnt counts 0..K-2. On tail_fire with tail_cnt==K-2: out_last=1, state -> IDLE. sr is all-zero by construction at that point.
- out_last is 0 on every data symbol when ENC_TAIL_EN is defined.
- Boundaries:
  - Back-to-back frames: the next frame's first bit is accepted only in IDLE, the cycle after the last tail symbol is loaded (subject to out_ready).
  - Bits are not dropped or duplicated under any out_ready pattern.
  - A single-bit frame emits exactly 1+(K-1) symbols.
  - in_last without in_valid is ignored.
  - rst in any state, including mid-tail or a stalled output, discards the pending symbol and returns to IDLE next cycle with sr=0.
  - While a symbol is stalled, state, sr and tail_cnt do not change.

Optional Feature:
- Macro: ENC_TAIL_EN.
- Defined: tail termination as described above; frame length in symbols = N+K-1.
- Undefined: no TAIL state.
  - in_fire with in_last=1 loads the data symbol with out_last=1, clears sr to 0 in the same cycle, and the state goes to IDLE.
  - Frame length = N symbols; in_ready never drops for tail.

Test Plan:
- G=7,5, ENC_TAIL_EN, frame 1,0,1,1 (last on the 4th bit), out_ready=1 -> out_sym 11,10,00,01,01,11 on consecutive cycles; out_last only on the 6th; in_ready=0 for 2 cycles after the last bit.
- Single-bit frame 1 (last) -> 11,10,11 with out_last on the 3rd; a second frame 0 (last) immediately after -> 00,00,00.
- Same 1,0,1,1 frame with out_ready toggling 1,0,0,1,... -> identical symbol sequence. out_sym stable while stalled; in_ready=0 whenever out_valid & !out_ready.
- rst asserted on the cycle after the first tail symbol loads -> out_valid=0, busy=0 the next cycle. A following frame 1 (last) yields 11,10,11, showing sr was cleared.
- ENC_TAIL_EN undefined, frame 1,0,1,1 -> 11,10,00,01 with out_last on 01. Next frame 1 (last) -> 11, showing sr was cleared.
- Continuous 64-bit random frame versus the bench reference encoder -> all 66 symbols match; 1 symbol/clk throughput with out_ready=1.
